// File: rtl/object_pkg.sv
// Shared definitions for the object scan renderer: object codes, screen and
// coordinate widths, FSM state encoding and the generator colour select.
package object_pkg;

  localparam int SCREEN_W = 160;
  localparam int COLOUR_W = 3;
  localparam int DIST_W   = 4;
  localparam int Y_W      = 7;
  localparam int X_W      = 8;

  typedef enum logic [1:0] {
    OBJ_NONE  = 2'd0,
    OBJ_BENCH = 2'd1,
    OBJ_TREE  = 2'd2
  } obj_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    PLOT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Code 3 is reserved and renders like OBJ_NONE.
  function automatic logic [COLOUR_W-1:0] select_colour(
    input logic [1:0]          sel,
    input logic [COLOUR_W-1:0] c_none,
    input logic [COLOUR_W-1:0] c_bench,
    input logic [COLOUR_W-1:0] c_tree
  );
    case (sel)
      OBJ_BENCH: select_colour = c_bench;
      OBJ_TREE:  select_colour = c_tree;
      default:   select_colour = c_none;
    endcase
  endfunction

endpackage

// File: rtl/object_scan_renderer_scan_counter.sv
// Row-major y/distance walker for the object scan; wraps back to the first
// coordinate after the last one so the next scan starts clean.
module scan_counter
  import object_pkg::*;
#(
  parameter int Y_START = 60,
  parameter int Y_END   = 119
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [Y_W-1:0]    y,
  output logic [DIST_W-1:0] distance,
  output logic              last
);

  localparam logic [Y_W-1:0] Y_FIRST = Y_W'(Y_START);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(Y_END);

  assign last = (y == Y_LAST) && (distance == '1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      y        <= Y_FIRST;
      distance <= '0;
    end else if (advance) begin
      if (last) begin
        y        <= Y_FIRST;
        distance <= '0;
      end else if (distance == '1) begin
        y        <= y + 1'b1;
        distance <= '0;
      end else begin
        distance <= distance + 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_scan_renderer.sv
// Scans an object's bounding box through the colour generators and offers each
// visible pixel to the VGA adapter. Define TRANSPARENT_EN to drop pixels whose
// colour equals TRANSPARENT_COLOUR.
module object_scan_renderer
  import object_pkg::*;
#(
  parameter int                   Y_START            = 60,
  parameter int                   Y_END              = 119,
  parameter logic [COLOUR_W-1:0]  TRANSPARENT_COLOUR = 3'b011
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x_base,
  input  logic [1:0]          obj_sel,
  output logic [Y_W-1:0]      obj_y,
  output logic [DIST_W-1:0]   obj_distance,
  input  logic [COLOUR_W-1:0] colour_none,
  input  logic [COLOUR_W-1:0] colour_bench,
  input  logic [COLOUR_W-1:0] colour_tree,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_valid,
  input  logic                plot_ready,
  output logic                busy,
  output logic                done
);

`ifdef TRANSPARENT_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  localparam logic [X_W:0] X_MAX = (X_W + 1)'(SCREEN_W - 1);

  state_t              state;
  logic [X_W-1:0]      x_lat;
  logic [1:0]          sel_lat;
  logic [X_W:0]        x_sum;
  logic [COLOUR_W-1:0] sel_colour;
  logic                skip;
  logic                advance;
  logic                clear;
  logic                last;

  // Nine-bit sum so columns past the screen edge never wrap back onto it.
  assign x_sum      = {1'b0, x_lat} + {{(X_W + 1 - DIST_W){1'b0}}, obj_distance};
  assign sel_colour = select_colour(sel_lat, colour_none, colour_bench, colour_tree);
  assign skip       = (x_sum > X_MAX) ||
                      (TRANSP_EN && (sel_colour == TRANSPARENT_COLOUR));
  assign advance    = ((state == WAIT) && skip) ||
                      ((state == PLOT) && plot_ready);
  assign clear      = (state == IDLE) && start;

  scan_counter #(
    .Y_START (Y_START),
    .Y_END   (Y_END)
  ) u_scan_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .advance  (advance),
    .y        (obj_y),
    .distance (obj_distance),
    .last     (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      x_lat       <= '0;
      sel_lat     <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_lat   <= x_base;
            sel_lat <= obj_sel;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        // Generator colour for the issued coordinate is valid during WAIT.
        WAIT: begin
          plot_colour <= sel_colour;
          if (skip) begin
            done  <= last;
            state <= last ? DONE : ISSUE;
          end else begin
            plot_x     <= x_sum[X_W-1:0];
            plot_y     <= obj_y;
            plot_valid <= 1'b1;
            state      <= PLOT;
          end
        end
        PLOT: begin
          if (plot_ready) begin
            plot_valid <= 1'b0;
            done       <= last;
            state      <= last ? DONE : ISSUE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_object_scan_renderer.sv
// Scoreboard bench for object_scan_renderer with behavioural colour generators.
module tb_object_scan_renderer;

`ifdef TRANSPARENT_EN
  localparam bit TB_TRANSP = 1'b1;
`else
  localparam bit TB_TRANSP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_base = '0;
  logic [1:0] obj_sel = '0;
  logic [6:0] obj_y;
  logic [3:0] obj_distance;
  logic [2:0] colour_none = '0, colour_bench = '0, colour_tree = '0;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;
  logic       plot_valid;
  logic       plot_ready = 1'b1;
  logic       busy, done;

  object_scan_renderer dut (
    .clock(clock), .reset(reset), .start(start), .x_base(x_base), .obj_sel(obj_sel),
    .obj_y(obj_y), .obj_distance(obj_distance), .colour_none(colour_none),
    .colour_bench(colour_bench), .colour_tree(colour_tree), .plot_x(plot_x),
    .plot_y(plot_y), .plot_colour(plot_colour), .plot_valid(plot_valid),
    .plot_ready(plot_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] bench_col(input int y, input int d);
    if (y >= 75 && y <= 119 && d >= 2 && d <= 9) return 3'b011;
    return {1'b1, 2'(d)};
  endfunction

  function automatic logic [2:0] tree_col(input int y, input int d);
    return 3'(y + d);
  endfunction

  function automatic logic [2:0] model_col(input logic [1:0] sel, input int y, input int d);
    case (sel)
      2'd1:    return bench_col(y, d);
      2'd2:    return tree_col(y, d);
      default: return 3'b001;
    endcase
  endfunction

  // Generators register their colour one cycle after the coordinate.
  always @(posedge clock) begin
    colour_none  <= 3'b001;
    colour_bench <= bench_col(int'(obj_y), int'(obj_distance));
    colour_tree  <= tree_col(int'(obj_y), int'(obj_distance));
  end

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];
  int hs_count = 0;
  int done_cnt = 0;
  int exp_count = 0;
  logic [14:0] first_xy, last_xy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_scan(input logic [1:0] sel, input logic [7:0] xb);
    exp_count = 0;
    for (int y = 60; y <= 119; y++) begin
      for (int d = 0; d < 16; d++) begin
        int x;
        logic [2:0] c;
        x = int'(xb) + d;
        c = model_col(sel, y, d);
        if (x <= 159 && !(TB_TRANSP && c == 3'b011)) begin
          exp_q.push_back({8'(x), 7'(y), c});
          exp_count++;
        end
      end
    end
  endtask

  task automatic start_scan(input logic [1:0] sel, input logic [7:0] xb);
    push_scan(sel, xb);
    hs_count = 0;
    obj_sel = sel;
    x_base = xb;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clock);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int limit);
    int base;
    bit seen;
    base = done_cnt;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    @(negedge clock);
    check("done_single_pulse", done_cnt - base, 1);
    check("busy_cleared", busy, 0);
    check("done_low", done, 0);
    check("handshakes", hs_count, exp_count);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clock) begin
    if (!reset && plot_valid && plot_ready) begin
      check("x_in_bounds", (plot_x < 8'd160), 1);
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", {plot_x, plot_y, plot_colour}, 0);
      end else begin
        check("pixel", {plot_x, plot_y, plot_colour}, exp_q.pop_front());
      end
      if (hs_count == 0) first_xy = {plot_x, plot_y};
      last_xy = {plot_x, plot_y};
      hs_count++;
    end
    if (!reset && done) begin
      done_cnt++;
      check("queue_empty_at_done", exp_q.size(), 0);
      check("no_valid_at_done", plot_valid, 0);
    end
  end

  initial begin
    logic [17:0] held;
    int base;
    bit seen;

    // Reset held two cycles, then idle with start low.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_plot_valid", plot_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_obj_y", obj_y, 60);
    check("rst_obj_distance", obj_distance, 0);
    check("rst_plot_x", plot_x, 0);
    check("rst_plot_y", plot_y, 0);
    check("rst_plot_colour", plot_colour, 0);
    repeat (4) tick();
    @(negedge clock);
    check("idle_busy", busy, 0);
    check("idle_valid", plot_valid, 0);

    // Full tree scan from column 10.
    start_scan(2'd2, 8'd10);
    wait_done(20000);
    check("first_xy", first_xy, {8'd10, 7'd60});
    check("last_xy", last_xy, {8'd25, 7'd119});
    if (!TB_TRANSP) check("tree_count_960", hs_count, 960);

    // Back-pressure on the first pixel.
    plot_ready = 1'b0;
    start_scan(2'd2, 8'd10);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (plot_valid) seen = 1;
    end
    check("stall_valid_seen", seen, 1);
    held = {plot_x, plot_y, plot_colour};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_hold_pixel", {plot_x, plot_y, plot_colour}, held);
      check("stall_hold_valid", plot_valid, 1);
      check("stall_no_advance", obj_distance, 0);
    end
    tick();
    plot_ready = 1'b1;
    wait_done(20000);

    // Right edge clipping.
    start_scan(2'd0, 8'd150);
    wait_done(20000);
    check("edge_count_600", hs_count, 600);
    check("edge_last_x", last_xy[14:7], 159);

    // Ignored restart, then reset mid-scan.
    base = done_cnt;
    start_scan(2'd2, 8'd0);
    for (int i = 0; i < 2000 && hs_count < 100; i++) begin
      tick();
      if (hs_count == 50) begin
        start = 1'b1;
        obj_sel = 2'd1;
        x_base = 8'd77;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("reached_pixel_100", hs_count, 100);
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("abort_valid", plot_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_obj_y", obj_y, 60);
    reset = 1'b0;
    repeat (20) tick();
    check("abort_no_done", done_cnt - base, 0);
    exp_q.delete();

    // Bench object: transparency only with the macro defined.
    start_scan(2'd1, 8'd20);
    wait_done(20000);
    check("bench_count", hs_count, TB_TRANSP ? 600 : 960);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/object_scan_renderer.md
OBJECT_SCAN_RENDERER -- requirements
Module: object_scan_renderer

Interface
REQ-001 SHALL have parameter Y_START, default 60, meaning the first scanned row.
REQ-002 SHALL have parameter Y_END, default 119, meaning the last scanned row; Y_START <= Y_END <= 119 is required.
REQ-003 SHALL have parameter TRANSPARENT_COLOUR, default 3'b011, meaning the colour suppressed when TRANSPARENT_EN is defined.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: requests a scan, sampled only in IDLE.
REQ-007 SHALL have port x_base, input, 8 bits: screen column of distance 0, latched on an accepted start.
REQ-008 SHALL have port obj_sel, input, 2 bits: object select (0 none, 1 bench, 2 tree, 3 treated as none), latched on an accepted start.
REQ-009 SHALL have port obj_y, output, 7 bits: row driven to the object generators.
REQ-010 SHALL have port obj_distance, output, 4 bits: column offset driven to the object generators.
REQ-011 SHALL have ports colour_none, colour_bench and colour_tree, input, 3 bits each: registered generator outputs with 1-cycle latency.
REQ-012 SHALL have ports plot_x (8 bits), plot_y (7 bits) and plot_colour (3 bits), all outputs: the pixel offered to the VGA adapter.
REQ-013 SHALL have port plot_valid, output, and port plot_ready, input, 1 bit each: the pixel handshake.
REQ-014 SHALL have ports busy and done, output, 1 bit each: busy is high from the cycle after an accepted start until the done cycle inclusive; done is a 1-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, PLOT, DONE.
REQ-016 SHALL go IDLE->ISSUE on start, with coordinates y=Y_START and distance=0; start in any other state SHALL be ignored.
REQ-017 SHALL hold obj_y/obj_distance at the current coordinate in ISSUE, WAIT and PLOT, and go ISSUE->WAIT unconditionally.
REQ-018 SHALL, at the end of WAIT, capture the colour selected by the latched obj_sel into plot_colour, and go to PLOT unless the pixel is skipped.
REQ-019 SHALL skip a pixel (WAIT->advance, no PLOT) when x_base+distance > 159, computed 9-bit with no wrap.
REQ-020 SHALL assert plot_valid only in PLOT, with plot_x=x_base+distance and plot_y=obj_y; plot_x/plot_y/plot_colour SHALL be stable while plot_valid && !plot_ready.
REQ-021 SHALL advance on a PLOT handshake (plot_valid && plot_ready) or on a skip: in row-major order distance increments; at 15, distance becomes 0 and y increments; after (y=Y_END, distance=15) the FSM goes to DONE, otherwise to ISSUE.
REQ-022 SHALL assert done for exactly one cycle in DONE and then return to IDLE.
REQ-023 SHALL plot every non-skipped pixel exactly once per scan, (Y_END-Y_START+1)*16 visits in total.

Reset
REQ-024 SHALL, on reset, force IDLE with plot_valid=0, busy=0, done=0, obj_y=Y_START, obj_distance=0, plot_x=0, plot_y=0, plot_colour=0, and latched x_base/obj_sel=0.
REQ-025 SHALL let reset asserted mid-scan abort the scan, with plot_valid low after that edge and no done pulse.

Configuration
REQ-026 SHALL, with TRANSPARENT_EN defined, also skip at WAIT any pixel whose selected colour equals TRANSPARENT_COLOUR.
REQ-027 SHALL, without TRANSPARENT_EN, plot all in-bounds pixels regardless of colour.

Structure
REQ-028 SHALL take from shared package object_pkg: the object codes OBJ_NONE/OBJ_BENCH/OBJ_TREE, SCREEN_W=160, COLOUR_W=3, DIST_W=4 and Y_W=7.
REQ-029 SHALL contain one sub-module, scan_counter, holding y/distance with clear, advance and last outputs.

Verification
REQ-030 SHALL cover: reset held 2 cycles, then released -> all outputs at reset values, and start low -> remains IDLE.
REQ-031 SHALL cover: obj_sel=2, x_base=10, plot_ready=1, no macro -> 960 handshakes, first (10,60), last (25,119), done a single pulse after the last handshake.
REQ-032 SHALL cover: plot_ready=0 for 5 cycles on the first pixel -> plot_x/plot_y/plot_colour stable and no advance, then one handshake.
REQ-033 SHALL cover: x_base=150 -> only x 150..159 plotted, 600 handshakes, no x >= 160.
REQ-034 SHALL cover: start pulsed mid-scan -> ignored; reset at pixel 100 -> plot_valid=0 and busy=0 next cycle, no done pulse.
REQ-035 SHALL cover: TRANSPARENT_EN with obj_sel=1 and bench model -> handshakes only where bench colour != 3'b011 (rows 75..119, distances 2..9), count matching the reference model.
